// File: rtl/mnet_pkg.sv
// rtl/mnet_pkg.sv - shared frame geometry, pixel/frame types and loader state encoding
package mnet_pkg;

    localparam int INPUT_SIZE     = 32;
    localparam int INPUT_CHANNELS = 3;
    localparam int PX_SIZE        = 8;

    typedef logic [PX_SIZE-1:0] pixel_t;

    // Same packing as the network's img_in: [row][col][ch][bit]
    typedef pixel_t [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0] frame_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - nested ch/col/row raster position counter with clear and last flag
module raster_counter
    import mnet_pkg::*;
#(
    parameter int SIZE     = INPUT_SIZE,
    parameter int CHANNELS = INPUT_CHANNELS,
    parameter int POS_W    = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col,
    output logic [CH_W-1:0]  ch,
    output logic             at_last
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(SIZE - 1);
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CHANNELS - 1);

    assign at_last = (row == POS_MAX) && (col == POS_MAX) && (ch == CH_MAX);

    // clear wins over advance so an accepted frame-ending sample rewinds to origin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            ch  <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
            ch  <= '0;
        end else if (advance) begin
            if (ch == CH_MAX) begin
                ch <= '0;
                if (col == POS_MAX) begin
                    col <= '0;
                    row <= (row == POS_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                ch <= ch + 1'b1;
            end
        end
    end

endmodule

// File: rtl/img_stream_loader.sv
// rtl/img_stream_loader.sv - assembles a raster sample stream into one held frame for minimobilenet
module img_stream_loader
    import mnet_pkg::*;
#(
    parameter int INPUT_SIZE     = mnet_pkg::INPUT_SIZE,
    parameter int INPUT_CHANNELS = mnet_pkg::INPUT_CHANNELS,
    parameter int PX_SIZE        = mnet_pkg::PX_SIZE,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PX_SIZE-1:0]   s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] img_data,
    output logic                 img_valid,
    input  logic                 img_ready,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frame_count
);

    localparam int POS_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int CH_W  = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;

    state_t           state;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
    logic [CH_W-1:0]  ch;
    logic             at_last;
    logic             accept;

    assign accept = s_valid & s_ready;

    raster_counter #(
        .SIZE     (INPUT_SIZE),
        .CHANNELS (INPUT_CHANNELS),
        .POS_W    (POS_W),
        .CH_W     (CH_W)
    ) u_raster_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept & (at_last | s_last)),
        .advance (accept),
        .row     (row),
        .col     (col),
        .ch      (ch),
        .at_last (at_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            s_ready     <= 1'b0;
            img_valid   <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
            img_data    <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    // also produces the first s_ready rise after reset release
                    s_ready <= 1'b1;
                    if (accept) begin
                        img_data[row][col][ch] <= s_data;
                        if (at_last) begin
                            state     <= HOLD;
                            s_ready   <= 1'b0;
                            img_valid <= 1'b1;
                            frame_err <= ~s_last;
                        end else begin
                            frame_err <= s_last;
                        end
                    end
                end
                HOLD: begin
                    if (img_ready) begin
                        state       <= FILL;
                        img_valid   <= 1'b0;
                        s_ready     <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_stream_loader.sv
// tb/tb_img_stream_loader.sv - directed and randomized self-checking bench for img_stream_loader
module tb_img_stream_loader;

    localparam int S  = 32;
    localparam int C  = 3;
    localparam int NS = S * S * C;

    typedef logic [S-1:0][S-1:0][C-1:0][7:0] img_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    img_t        img_data;
    logic        img_valid;
    logic        img_ready;
    logic        frame_err;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    img_stream_loader dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .img_data    (img_data),
        .img_valid   (img_valid),
        .img_ready   (img_ready),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ref_buf [NS];
    int         ref_pos   = 0;
    int         exp_count = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic img_t model_img();
        img_t m;
        for (int i = 0; i < NS; i++)
            m[i / (S * C)][(i / C) % S][i % C] = ref_buf[i];
        return m;
    endfunction

    task automatic chk_img(input string tag);
        img_t e;
        int   bad;
        e   = model_img();
        bad = -1;
        for (int i = NS - 1; i >= 0; i--)
            if (img_data[i / (S * C)][(i / C) % S][i % C] !== e[i / (S * C)][(i / C) % S][i % C])
                bad = i;
        n_checks++;
        assert (img_data === e) else begin
            n_fail++;
            if (bad >= 0)
                $error("FAIL %s: sample %0d observed 0x%0h expected 0x%0h", tag, bad,
                       img_data[bad / (S * C)][(bad / C) % S][bad % C], ref_buf[bad]);
            else
                $error("FAIL %s: img_data differs from model frame", tag);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) ref_buf[i] = 8'h00;
        ref_pos   = 0;
        exp_count = 0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int guard;
        bit fin;
        int r, c, k;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        guard   = 0;
        while (s_ready !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("s_ready_wait", 64'(guard < 200), 64'd1);
        r = ref_pos / (S * C);
        c = (ref_pos / C) % S;
        k = ref_pos % C;
        ref_buf[ref_pos] = d;
        fin = (ref_pos == NS - 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("write", img_data[r][c][k], d);
        chk("img_valid", img_valid, fin);
        chk("s_ready", s_ready, !fin);
        chk("frame_err", frame_err, fin ? !last : last);
        ref_pos = (fin || last) ? 0 : ref_pos + 1;
    endtask

    task automatic stream(input int count, input bit ramp, input bit last_at_end, input bit gaps);
        for (int n = 0; n < count; n++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(ramp ? 8'(n) : 8'($urandom), last_at_end && (n == count - 1));
        end
    endtask

    task automatic deliver(input int wait_cycles, input logic drive_valid);
        chk_img("frame_content");
        img_ready = 1'b0;
        s_valid   = drive_valid;
        s_data    = 8'($urandom);
        for (int i = 0; i < wait_cycles; i++) begin
            @(posedge clk);
            #1;
            chk("hold_s_ready", s_ready, 1'b0);
            chk("hold_img_valid", img_valid, 1'b1);
            chk_img("hold_stable");
        end
        img_ready = 1'b1;
        @(posedge clk);
        #1;
        img_ready = 1'b0;
        s_valid   = 1'b0;
        exp_count++;
        chk("ack_img_valid", img_valid, 1'b0);
        chk("ack_s_ready", s_ready, 1'b1);
        chk("frame_count", frame_count, 64'(exp_count[15:0]));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #2;
        model_clear();
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_img_valid", img_valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_frame_count", frame_count, 64'd0);
        chk_img("rst_img_data");
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("release_s_ready_low", s_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("release_s_ready_high", s_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        s_data    = 8'h00;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        img_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset_dut();

        // ramp frame with img_ready held high throughout
        img_ready = 1'b1;
        stream(NS, 1'b1, 1'b1, 1'b0);
        chk("count_before_ack", frame_count, 64'd0);
        chk("px_0_0_0", img_data[0][0][0], 64'h00);
        chk("px_0_0_2", img_data[0][0][2], 64'h02);
        chk("px_0_1_0", img_data[0][1][0], 64'h03);
        chk("px_31_31_2", img_data[31][31][2], 64'hFF);
        deliver(0, 1'b0);

        // held frame with upstream pushing for 20 cycles
        stream(NS, 1'b0, 1'b1, 1'b0);
        deliver(20, 1'b1);
        begin
            logic [7:0] d;
            d = 8'($urandom);
            send(d, 1'b0);
            chk("next_at_origin", img_data[0][0][0], d);
        end

        // early s_last on sample 100 discards the partial frame
        stream(98, 1'b0, 1'b0, 1'b0);
        send(8'($urandom), 1'b1);
        idle(1);
        chk("early_last_no_valid", img_valid, 1'b0);
        chk("early_last_err_once", frame_err, 1'b0);
        stream(NS, 1'b0, 1'b1, 1'b0);
        deliver(2, 1'b0);

        // full frame without s_last still delivers
        stream(NS, 1'b0, 1'b0, 1'b0);
        chk("no_last_count_pre", frame_count, 64'(exp_count[15:0]));
        deliver(0, 1'b0);

        // reset in the middle of a frame
        stream(1500, 1'b0, 1'b0, 1'b0);
        reset_dut();
        stream(NS, 1'b0, 1'b1, 1'b0);
        deliver(1, 1'b0);

        // randomized gaps over five frames from a clean start
        reset_dut();
        for (int f = 0; f < 5; f++) begin
            stream(NS, 1'b0, 1'b1, 1'b1);
            deliver($urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end
        chk("frame_count_5", frame_count, 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/img_stream_loader.md
Name: img_stream_loader

Overview:
- Input stage directly upstream of minimobilenet.
- Accepts a raster pixel stream over a valid/ready handshake and assembles one complete INPUT_SIZE x INPUT_SIZE x INPUT_CHANNELS frame in a register buffer.
- Presents the frame on a packed bus matching the network's img_in layout, then holds it until the consumer acknowledges.
- Double-handshake boundary: the stream side stalls while a frame is held.

Parameters:
- INPUT_SIZE, 32, frame height and width in pixels (square).
- INPUT_CHANNELS, 3, channels per pixel.
- PX_SIZE, 8, bits per channel sample.
- CNT_W, 16, width of the delivered-frame counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_data  input  PX_SIZE  one channel sample.
- s_valid  input  1  s_data valid.
- s_last  input  1  marks the final sample of a frame.
- s_ready  output  1  loader accepts a sample this cycle.
- img_data  output  [INPUT_SIZE][INPUT_SIZE][INPUT_CHANNELS][PX_SIZE]  assembled frame, packed [row][col][ch][bit]; connects to minimobilenet img_in.
- img_valid  output  1  img_data holds a complete frame.
- img_ready  input  1  consumer takes the frame.
- frame_err  output  1  one-cycle pulse on s_last mismatch.
- frame_count  output  CNT_W  number of frames delivered; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release):
  - state=FILL; row, col and ch counters = 0.
  - s_ready=0, img_valid=0, frame_err=0, frame_count=0, img_data all zeros.
- s_ready is registered. It rises on the first clk edge after rst deasserts.
- Sample order: ch fastest, then col, then row. Sample n lands at img_data[row][col][ch].
- Accept = s_valid & s_ready. Each accept:
  - writes s_data into img_data[row][col][ch];
  - advances ch; on ch wrap, advances col; on col wrap, advances row.
- State FILL:
  - s_ready=1, img_valid=0.
  - Accepting the final sample (row=col=INPUT_SIZE-1, ch=INPUT_CHANNELS-1):
    - next cycle: state=HOLD, s_ready=0, img_valid=1;
    - counters return to 0.
  - Latency: img_valid rises 1 cycle after the final accept.
- State HOLD:
  - img_data is frozen; no buffer writes; s_ready=0.
  - On img_valid & img_ready:
    - next cycle: img_valid=0, s_ready=1, state=FILL;
    - frame_count increments.
  - img_data is not cleared. The next frame overwrites it sample by sample.
- s_last checks (evaluated only on accept):
  - s_last=1 on a non-final sample:
    - frame_err pulses next cycle;
    - counters reset to 0; partial frame discarded; state stays FILL;
    - already-written buffer entries are left as is.
  - Final sample with s_last=0: frame_err pulses; frame is still delivered normally.
  - Final sample with s_last=1: no error.
- s_valid while s_ready=0: ignored. The upstream holds data per the handshake.
- img_ready while img_valid=0: ignored.
- Reset mid-frame or mid-HOLD: all state discarded immediately; outputs take their reset values asynchronously.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared package mnet_pkg:
  - localparams for INPUT_SIZE, INPUT_CHANNELS, PX_SIZE;
  - pixel typedef logic [PX_SIZE-1:0];
  - frame typedef matching the network img_in packing;
  - state enum {FILL, HOLD}.
- One natural sub-module: raster_counter (nested ch/col/row counter with a synchronous clear and a last-position flag).
- Buffer and handshake FSM stay in the top.

Test Plan:
- Stream 3072 samples, value = n mod 256, s_last on the last one, img_ready held 1 -> img_valid 1 cycle after the final accept; img_data[0][0][0]=0, [0][0][2]=2, [0][1][0]=3, [31][31][2]=0xFF (3071 mod 256); frame_err never set; frame_count=1.
- Frame complete with img_ready=0 for 20 cycles while s_valid=1 -> s_ready=0 and img_data stable throughout; img_ready=1 -> s_ready=1 next cycle; the next sample goes to [0][0][0].
- s_last on sample 100 of a frame -> frame_err pulses once; no img_valid; the following 3072-sample frame is delivered with its first sample at [0][0][0].
- Full frame without s_last -> frame_err pulse and img_valid=1 in the same cycle; frame_count increments after the handshake.
- rst asserted after 1500 samples -> s_ready/img_valid=0 immediately and img_data=0; a fresh 3072-sample frame after release is delivered correctly.
- Random s_valid/img_ready gaps over 5 frames -> every frame matches the scoreboard; frame_count=5.
